sm_addsub_acc: RTL

SM_ADDSUB_ACC -- requirements
Module: sm_addsub_acc

---
 rtl/sm_addsub_acc.sv | 72 +++++++
 1 files changed

// File: rtl/sm_addsub_acc.sv
// sm_addsub_acc: two-stage add/sub/accumulate pipeline with valid/ready handshake.
// Macro SM_ADDSUB_SAT_EN selects a saturating accumulator; otherwise it wraps.
module sm_addsub_acc #(
  parameter int W = 8,
  parameter int ACC_W = 16,
  parameter int B_SM = 1
) (
  input  logic             Clk_in,
  input  logic             Rst_in,
  input  logic [W-1:0]     A_in,
  input  logic [W-1:0]     B_in,
  input  logic [1:0]       Op_in,
  input  logic             Valid_in,
  output logic             Ready_out,
  output logic [W:0]       Rez_out,
  output logic [ACC_W-1:0] Acc_out,
  output logic             Ovf_out,
  output logic             Valid_out,
  input  logic             Ready_in
);
  localparam logic [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
  localparam logic [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};
  logic             s1_v, s2_v, s2_adv, move;
  logic [W-1:0]     s1_a, s1_b, bp;
  logic [1:0]       s1_op;
  logic [W:0]       a_x, b_x, rez_n;
  logic [ACC_W:0]   sum;
  logic [ACC_W-1:0] acc, acc_add, acc_n;
  logic             ovf_n;
  // Negative zero falls out naturally: -(0) is 0.
  always_comb bp = (B_SM != 0 && B_in[W-1]) ? -{1'b0, B_in[W-2:0]} : B_in;
  assign s2_adv = !s2_v || Ready_in;
  assign move = s1_v && s2_adv;
  assign Ready_out = !s1_v || s2_adv;
  assign Valid_out = s2_v;
  assign Acc_out = acc;
  always_comb begin
    a_x = {s1_a[W-1], s1_a};
    b_x = {s1_b[W-1], s1_b};
    sum = {acc[ACC_W-1], acc} + {{(ACC_W-W+1){s1_b[W-1]}}, s1_b};
    ovf_n = (s1_op == 2'b10) && (sum[ACC_W] != sum[ACC_W-1]);
`ifdef SM_ADDSUB_SAT_EN
    acc_add = ovf_n ? (sum[ACC_W] ? ACC_MIN : ACC_MAX) : sum[ACC_W-1:0];
`else
    acc_add = sum[ACC_W-1:0];
`endif
    acc_n = s1_op == 2'b11 ? {{(ACC_W-W){s1_a[W-1]}}, s1_a} : s1_op == 2'b10 ? acc_add : acc;
    rez_n = s1_op == 2'b00 ? a_x + b_x : s1_op == 2'b01 ? a_x - b_x : s1_op == 2'b10 ? b_x : a_x;
  end
  always_ff @(posedge Clk_in) begin
    if (Rst_in) begin
      s1_v <= 1'b0;
      s2_v <= 1'b0;
      acc <= '0;
      Rez_out <= '0;
      Ovf_out <= 1'b0;
    end else begin
      if (Ready_out) s1_v <= Valid_in;
      if (Ready_out && Valid_in) begin
        s1_a <= A_in;
        s1_b <= bp;
        s1_op <= Op_in;
      end
      if (s2_adv) s2_v <= s1_v;
      if (move) begin
        acc <= acc_n;
        Rez_out <= rez_n;
        Ovf_out <= ovf_n;
      end
    end
  end
endmodule
